// File: rtl/jk_down_counter.sv
// Loadable synchronous down-counter built from toggle cells on a ripple-borrow chain,
// with busy flag and one-cycle done pulse. Optional periodic mode: JK_DOWN_COUNTER_AUTORELOAD_EN.
module jk_down_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic [WIDTH-1:0] out,
   output logic             busy,
   output logic             done
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_p0, state_nxt;
   logic [WIDTH-1:0] cnt_p0, cnt_nxt;
   logic             done_p0, done_nxt;
   logic             count_go;
   logic             terminal;
   logic             load_zero;
   logic [WIDTH-1:0] toggle;

   // Bit i toggles when counting and every lower bit is 0 (borrow ripples upward).
   function automatic logic [WIDTH-1:0] borrow_toggle(input logic go,
                                                       input logic [WIDTH-1:0] q);
      logic [WIDTH-1:0] t;
      t[0] = go;
      for (int i = 1; i < WIDTH; i++) begin
         t[i] = t[i-1] & ~q[i-1];
      end
      return t;
   endfunction

   assign count_go  = (state_p0 == RUN) && en && !load;
   assign toggle    = borrow_toggle(count_go, cnt_p0);
   assign terminal  = count_go && (cnt_p0 == WIDTH'(1));
   assign load_zero = (load_val == '0);

`ifdef JK_DOWN_COUNTER_AUTORELOAD_EN
   logic [WIDTH-1:0] reload_p0;

   always_ff @(posedge clk) begin
      if (rst) begin
         reload_p0 <= '0;
      end else if (load) begin
         reload_p0 <= load_val;
      end
   end
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_p0 <= IDLE;
      end else begin
         state_p0 <= state_nxt;
      end
   end

   // Next-state logic: load takes priority over the terminal decrement.
   always_comb begin
      state_nxt = state_p0;
      if (load) begin
         state_nxt = load_zero ? IDLE : RUN;
      end else if (terminal) begin
`ifdef JK_DOWN_COUNTER_AUTORELOAD_EN
         state_nxt = RUN;
`else
         state_nxt = IDLE;
`endif
      end
   end

   // Output logic: next count and done pulse
   always_comb begin
      cnt_nxt  = cnt_p0 ^ toggle;
      done_nxt = 1'b0;
      if (load) begin
         cnt_nxt  = load_val;
         done_nxt = load_zero;
      end else if (terminal) begin
         done_nxt = 1'b1;
`ifdef JK_DOWN_COUNTER_AUTORELOAD_EN
         cnt_nxt  = reload_p0;
`endif
      end
   end

   // Registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_p0  <= '0;
         done_p0 <= 1'b0;
      end else begin
         cnt_p0  <= cnt_nxt;
         done_p0 <= done_nxt;
      end
   end

   assign out  = cnt_p0;
   assign busy = (state_p0 == RUN);
   assign done = done_p0;

endmodule
